top_seq_2: RTL and testbench
============================

TOP_SEQ_2 -- requirements
Module: top_seq_2

Interface
REQ-001 Parameter CLK_HZ, default 27000000: input clock frequency in Hz.
REQ-002 Parameter SCAN_DIV, default 27000: clocks per digit-scan slot, about 1 kHz per digit.
REQ-003 Parameter STEP_DIV, default 13500000: clocks per scroll step at normal speed, 0.5 s.
REQ-004 Parameter DEB_DIV, default 270000: clocks a button level must stay stable before it is accepted, 10 ms.
REQ-005 Parameter SEQ, 32 bits, default 32'h2023_0415: 8-hex-digit ring; nibble 7 is the first element.
REQ-006 clk  input  1  system clock; one clock; all logic on its rising edge.
REQ-007 rst  input  1  reset; synchronous and active-high.
REQ-008 button  input  4  raw push-buttons, active-low (0 = pressed), asynchronous to clk.
REQ-009 dig  output  4  digit enables, active-low; dig[0] is the leftmost digit.
REQ-010 smg  output  8  segments, active-low; bit0..bit6 = a..g, bit7 = dp.

Function
REQ-011 Each button is synchronised with 2 flops, then debounced: the new level is accepted only after DEB_DIV consecutive equal samples.
REQ-012 A press event is a single one-clock pulse on the debounced 1->0 edge; holding a button produces no repeats.
REQ-013 button[0] toggles run/pause; pause freezes the scroll position and the step counter.
REQ-014 button[1] toggles direction: forward (pos+1) or reverse (pos-1).
REQ-015 button[2] toggles speed: normal (STEP_DIV) or fast (STEP_DIV/4); the step counter restarts from 0 on each toggle.
REQ-016 button[3] sets pos to 0 and clears the step counter; run, direction and speed are unchanged.
REQ-017 If button[3] and another button events in the same clock, button[3] wins for pos; the other toggles still apply.
REQ-018 While running, pos (3 bits) changes by one when the step counter reaches its terminal count; it wraps 7->0 forward and 0->7 reverse.
REQ-019 Display digit i (0..3) shows SEQ nibble (7 - ((pos + i) mod 8)), so pos = 0 shows "2023".
REQ-020 Scan: a 2-bit index advances every SCAN_DIV clocks, order 0,1,2,3,0; exactly one dig bit is low at a time.
REQ-021 dig and smg are registered and change in the same cycle: 1 clock latency from index change to outputs.
REQ-022 Hex-to-segment decoding covers 0-F using standard a..g patterns, active-low; for example, 0 -> 8'hC0 with dp off.

Reset
REQ-023 While rst = 1 at a clock edge:
- pos = 0; running = 1; direction = forward; speed = normal.
- All counters = 0; debounced levels = 1 (released); no events.
- dig = 4'b1110; smg = decode of digit 0 at pos 0 (8'hA4 for '2').
REQ-024 Reset asserted mid-step or mid-debounce discards the partial count; a held button is not seen as a press after reset until it is released and pressed again.

Configuration
REQ-025 Macro DP_INDICATOR_EN, when defined: dp (smg[7]) is lit (0) on digit 0 while paused and on digit 3 while in reverse; otherwise dp is off.
REQ-026 Without DP_INDICATOR_EN: smg[7] is constant 1 and no indicator logic is generated.

Structure
REQ-027 Shared package seg_pkg holds:
- the segment constants for 0-F and SEG_BLANK = 8'hFF;
- a function hex2seg;
- DIR_FWD / DIR_REV and SPD_NORM / SPD_FAST constants.
REQ-028 One sub-module, key_debounce, is instantiated 4 times; it provides sync, debounce and the press pulse, with DEB_DIV as its parameter.

Verification (small parameters: SCAN_DIV = 4, STEP_DIV = 16, DEB_DIV = 8)
REQ-029 Reset held 3 clocks, then released:
- dig = 1110 and smg = 8'hA4 during reset;
- after 4 clocks, dig = 1101 with digit '0' (8'hC0).
REQ-030 Free-run for 16 clocks -> pos = 1; digits read "0230". After 128 clocks, pos wraps back to 0.
REQ-031 button[1] held low for 10 clocks then released -> direction = reverse; the next step gives pos = 7, digits "5202".
REQ-032 button[0] press -> pos stays constant for 100 clocks. With DP_INDICATOR_EN, smg[7] = 0 while digit 0 is scanned.
REQ-033 button[0] bouncing 1-0-1-0 with periods under 8 clocks -> no event and no state change.
REQ-034 button[3] and button[2] pressed in the same clock -> pos = 0 and speed = fast; the next step follows after 4 clocks.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the scrolling 4-digit hex display:
// active-low 7-segment patterns (bit0..6 = a..g, bit7 = dp),
// the hex decoder, and the direction/speed encodings.
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_e;

  typedef enum logic {
    SPD_NORM = 1'b0,
    SPD_FAST = 1'b1
  } spd_e;

  // Active-low segment pattern for one hex digit, dp off
  function automatic logic [7:0] hex2seg(input logic [3:0] hex);
    logic [7:0] seg;
    case (hex)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low push-button: 2-flop synchroniser, debounce
// (level accepted after DEB_DIV consecutive differing samples)
// and a one-clock press pulse on the debounced 1->0 edge.
// After reset the button must be seen released for DEB_DIV
// samples before any press is reported, so a button held through
// reset does not fire.
module key_debounce #(
  parameter int unsigned DEB_DIV = 270000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_n,
  output logic o_press
);

  localparam int unsigned CW = $clog2(DEB_DIV + 1);
  localparam logic [CW-1:0] DEB_TC = CW'(DEB_DIV - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic          r_armed;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_hi_cnt;

  // Synchronise, debounce, arm after a confirmed release, pulse on press
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_level  <= 1'b1;
      r_press  <= 1'b0;
      r_armed  <= 1'b0;
      r_cnt    <= '0;
      r_hi_cnt <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;

      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DEB_TC) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= ~r_sync2 & r_armed;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (!r_armed) begin
        if (!r_sync2) begin
          r_hi_cnt <= '0;
        end else if (r_hi_cnt == DEB_TC) begin
          r_armed <= 1'b1;
        end else begin
          r_hi_cnt <= r_hi_cnt + 1'b1;
        end
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/top_seq_2.sv
// Scrolling 4-digit display of an 8-nibble ring (SEQ).
// Buttons (active-low): 0 run/pause, 1 direction, 2 speed,
// 3 home (pos = 0). Digits are multiplexed one at a time.
// Optional feature macro: DP_INDICATOR_EN -- decimal point on
// digit 0 while paused and on digit 3 while scrolling in reverse.
module top_seq_2
  import seg_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 27000000,
  parameter int unsigned SCAN_DIV = 27000,
  parameter int unsigned STEP_DIV = 13500000,
  parameter int unsigned DEB_DIV  = 270000,
  parameter logic [31:0] SEQ      = 32'h2023_0415
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] button,
  output logic [3:0] dig,
  output logic [7:0] smg
);

  // A zero divider falls back to a rate derived from the clock
  localparam int unsigned SCAN_SLOT = (SCAN_DIV == 0) ? (CLK_HZ / 1000) : SCAN_DIV;
  localparam int unsigned STEP_SLOT = (STEP_DIV == 0) ? (CLK_HZ / 2) : STEP_DIV;
  localparam int unsigned FAST_SLOT = ((STEP_SLOT / 4) == 0) ? 1 : (STEP_SLOT / 4);

  localparam int unsigned SCAN_W = $clog2(SCAN_SLOT + 1);
  localparam int unsigned STEP_W = $clog2(STEP_SLOT + 1);

  localparam logic [SCAN_W-1:0] SCAN_TC   = SCAN_W'(SCAN_SLOT - 1);
  localparam logic [STEP_W-1:0] STEP_TC_N = STEP_W'(STEP_SLOT - 1);
  localparam logic [STEP_W-1:0] STEP_TC_F = STEP_W'(FAST_SLOT - 1);

  localparam logic [7:0] SMG_RST = hex2seg(SEQ[31:28]);

  logic [3:0]        w_press;
  logic              w_step_tc;
  logic [2:0]        w_slot;
  logic [4:0]        w_shift;
  logic [3:0]        w_nib;
  logic [7:0]        w_seg;
  logic              w_dp;

  logic              r_run;
  dir_e              r_dir;
  spd_e              r_spd;
  logic [2:0]        r_pos;
  logic [STEP_W-1:0] r_step_cnt;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [1:0]        r_idx;
  logic [3:0]        r_dig;
  logic [7:0]        r_smg;

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debounce #(
      .DEB_DIV (DEB_DIV)
    ) u_key (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_btn_n (button[g]),
      .o_press (w_press[g])
    );
  end

  assign w_step_tc = (r_spd == SPD_FAST) ? (r_step_cnt == STEP_TC_F)
                                         : (r_step_cnt == STEP_TC_N);

  // Ring slot shown on the scanned digit; nibble 7 is slot 0
  assign w_slot  = r_pos + {1'b0, r_idx};
  assign w_shift = {~w_slot, 2'b00};
  assign w_nib   = SEQ[w_shift +: 4];
  assign w_seg   = hex2seg(w_nib);

`ifdef DP_INDICATOR_EN
  assign w_dp = ~(((r_idx == 2'd0) && !r_run) ||
                  ((r_idx == 2'd3) && (r_dir == DIR_REV)));
`else
  assign w_dp = 1'b1;
`endif

  // Run/direction/speed toggles and scroll position stepping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run      <= 1'b1;
      r_dir      <= DIR_FWD;
      r_spd      <= SPD_NORM;
      r_pos      <= '0;
      r_step_cnt <= '0;
    end else begin
      if (w_press[0]) r_run <= ~r_run;
      if (w_press[1]) r_dir <= (r_dir == DIR_FWD) ? DIR_REV : DIR_FWD;
      if (w_press[2]) r_spd <= (r_spd == SPD_NORM) ? SPD_FAST : SPD_NORM;

      // Home beats a simultaneous speed toggle for pos; both clear the count
      if (w_press[3]) begin
        r_pos      <= '0;
        r_step_cnt <= '0;
      end else if (w_press[2]) begin
        r_step_cnt <= '0;
      end else if (r_run) begin
        if (w_step_tc) begin
          r_step_cnt <= '0;
          r_pos      <= (r_dir == DIR_REV) ? (r_pos - 3'd1) : (r_pos + 3'd1);
        end else begin
          r_step_cnt <= r_step_cnt + 1'b1;
        end
      end
    end
  end

  // Digit scan slot timer and index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (r_scan_cnt == SCAN_TC) begin
      r_scan_cnt <= '0;
      r_idx      <= r_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // Registered digit enable and segment drive, updated together
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dig <= 4'b1110;
      r_smg <= SMG_RST;
    end else begin
      r_dig <= ~(4'b0001 << r_idx);
      r_smg <= w_seg & {w_dp, 7'h7F};
    end
  end

  assign dig = r_dig;
  assign smg = r_smg;

endmodule

// File: tb/tb_top_seq_2.sv
// Bench for top_seq_2 with small dividers. A cycle model driven
// by the same button/reset stimulus pushes the expected {dig,smg}
// into a queue every clock; the queue is popped and compared on the
// falling edge. Hand-timed checks cover reset and the first scroll
// steps; a table checks the hex decoder.
module tb_top_seq_2;

  localparam int SCAN = 4;
  localparam int STEP = 16;
  localparam int DEB  = 8;
  localparam logic [31:0] SEQ_TB = 32'h2023_0415;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] button = 4'hF;
  logic [3:0] dig;
  logic [7:0] smg;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0] nib;
    logic [7:0] seg;
  } hex_vec_t;

  typedef struct {
    logic [3:0] mask;
    int         hold;
    int         gap;
  } act_t;

  hex_vec_t   hex_tbl[16];
  act_t       act_tbl[8];
  logic [11:0] sb[$];

  top_seq_2 #(
    .SCAN_DIV (SCAN),
    .STEP_DIV (STEP),
    .DEB_DIV  (DEB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .dig    (dig),
    .smg    (smg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int pos, input int idx, input bit go, input bit rev);
    int         k;
    logic [3:0] nib;
    logic [7:0] s;
    k   = (pos + idx) % 8;
    nib = 4'(SEQ_TB >> (4 * (7 - k)));
    s   = hex_tbl[nib].seg;
`ifdef DP_INDICATOR_EN
    if ((idx == 0 && !go) || (idx == 3 && rev)) s[7] = 1'b0;
`endif
    return s;
  endfunction

  // Reference model
  bit m_s1[4], m_s2[4], m_lvl[4], m_arm[4];
  int m_cnt[4], m_hi[4];
  logic [3:0] m_evt;
  bit m_go, m_rev, m_fast;
  int m_pos, m_step, m_scan, m_idx;

  always @(posedge clk) begin : model
    logic [3:0] ev_new;
    logic [3:0] e_dig;
    logic [7:0] e_smg;
    int lim;
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        m_s1[b] = 1; m_s2[b] = 1; m_lvl[b] = 1; m_arm[b] = 0;
        m_cnt[b] = 0; m_hi[b] = 0;
      end
      m_evt = '0; m_go = 1; m_rev = 0; m_fast = 0;
      m_pos = 0; m_step = 0; m_scan = 0; m_idx = 0;
      e_dig = 4'b1110;
      e_smg = exp_seg(0, 0, 1'b1, 1'b0);
    end else begin
      e_dig = 4'b1111;
      e_dig[m_idx] = 1'b0;
      e_smg = exp_seg(m_pos, m_idx, m_go, m_rev);
      ev_new = '0;
      for (int b = 0; b < 4; b++) begin
        if (m_s2[b] == m_lvl[b]) m_cnt[b] = 0;
        else if (m_cnt[b] == DEB - 1) begin
          m_lvl[b] = m_s2[b];
          m_cnt[b] = 0;
          if (!m_s2[b] && m_arm[b]) ev_new[b] = 1'b1;
        end else m_cnt[b]++;
        if (!m_arm[b]) begin
          if (!m_s2[b]) m_hi[b] = 0;
          else if (m_hi[b] == DEB - 1) m_arm[b] = 1;
          else m_hi[b]++;
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = button[b];
      end
      lim = m_fast ? STEP / 4 : STEP;
      if (m_evt[3]) begin
        m_pos = 0; m_step = 0;
      end else if (m_evt[2]) begin
        m_step = 0;
      end else if (m_go) begin
        if (m_step == lim - 1) begin
          m_step = 0;
          m_pos  = m_rev ? (m_pos + 7) % 8 : (m_pos + 1) % 8;
        end else m_step++;
      end
      if (m_evt[0]) m_go   = !m_go;
      if (m_evt[1]) m_rev  = !m_rev;
      if (m_evt[2]) m_fast = !m_fast;
      if (m_scan == SCAN - 1) begin
        m_scan = 0;
        m_idx  = (m_idx + 1) % 4;
      end else m_scan++;
      m_evt = ev_new;
    end
    sb.push_back({e_dig, e_smg});
  end

  always @(negedge clk) begin
    logic [11:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("scoreboard dig/smg", {20'd0, dig, smg}, {20'd0, e});
    end
  end

  task automatic to_cycle(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] mask, input int hold, input int gap);
    button = ~mask;
    repeat (hold) @(negedge clk);
    button = 4'hF;
    repeat (gap) @(negedge clk);
  endtask

  task automatic chk_digit(input int n, input logic [3:0] d, input logic [7:0] s);
    to_cycle(n);
    chk("digit enable", {28'd0, dig}, {28'd0, d});
    chk("digit segments", {24'd0, smg}, {24'd0, s});
  endtask

  initial begin
    hex_tbl = '{'{4'h0, 8'hC0}, '{4'h1, 8'hF9}, '{4'h2, 8'hA4}, '{4'h3, 8'hB0},
                '{4'h4, 8'h99}, '{4'h5, 8'h92}, '{4'h6, 8'h82}, '{4'h7, 8'hF8},
                '{4'h8, 8'h80}, '{4'h9, 8'h90}, '{4'hA, 8'h88}, '{4'hB, 8'h83},
                '{4'hC, 8'hC6}, '{4'hD, 8'hA1}, '{4'hE, 8'h86}, '{4'hF, 8'h8E}};
    act_tbl = '{'{4'b0010, 10, 40},   // reverse
                '{4'b0001, 12, 100},  // pause
                '{4'b0001, 12, 30},   // resume
                '{4'b1100, 12, 30},   // home + fast in the same clock
                '{4'b0100, 12, 30},   // back to normal speed
                '{4'b0010, 12, 40},   // forward
                '{4'b1000, 12, 25},   // home alone
                '{4'b0011, 12, 60}};  // pause + reverse together

    rst = 1'b1;
    button = 4'hF;
    repeat (3) @(negedge clk);
    chk("reset dig", {28'd0, dig}, 32'h0000_000E);
    chk("reset smg", {24'd0, smg}, 32'h0000_00A4);
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      chk("hex2seg", {24'd0, seg_pkg::hex2seg(hex_tbl[i].nib)}, {24'd0, hex_tbl[i].seg});

    chk_digit(4, 4'b1110, 8'hA4);
    chk_digit(5, 4'b1101, 8'hC0);
    // pos = 1 -> "0230"
    chk_digit(17, 4'b1110, 8'hC0);
    chk_digit(21, 4'b1101, 8'hA4);
    chk_digit(25, 4'b1011, 8'hB0);
    chk_digit(29, 4'b0111, 8'hC0);
    // pos wrapped to 0 -> "2023"
    chk_digit(129, 4'b1110, 8'hA4);
    chk_digit(133, 4'b1101, 8'hC0);
    chk_digit(137, 4'b1011, 8'hA4);
    chk_digit(141, 4'b0111, 8'hB0);

    for (int i = 0; i < 8; i++)
      press(act_tbl[i].mask, act_tbl[i].hold, act_tbl[i].gap);

    // Bounce on button 0 just under the debounce length
    for (int r = 0; r < 3; r++) begin
      button = 4'hE;
      repeat (DEB - 1) @(negedge clk);
      button = 4'hF;
      @(negedge clk);
    end
    repeat (30) @(negedge clk);

    // Reset mid-debounce with button 1 held through and after reset
    button = 4'hD;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    button = 4'hF;
    repeat (20) @(negedge clk);
    press(4'b0010, 12, 40);

    // Random button activity
    repeat (40) begin
      button = 4'($urandom);
      if ($urandom_range(0, 1) == 1) button = 4'hF;
      repeat ($urandom_range(1, 14)) @(negedge clk);
    end
    button = 4'hF;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
